bp_pht_ctrl: RTL and testbench

- Sequencer and arbiter for a single-port 2-bit-counter pattern history table (PHT) RAM used for conditional-branch prediction.
- Initialises every table entry after reset.
- Arbitrates each RAM cycle between fetch-stage lookups and execute-stage branch-resolution updates. Updates are buffered in a small FIFO and applied as read-modify-write with saturating counters.
- Sits between IF (lookup), EX (resolution) and the PHT RAM macro.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_pht_ctrl_if.sv | 34 +++
 rtl/bp_upd_fifo.sv | 53 +++++
 rtl/bp_pht_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bp_pht_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit saturating counters,
// the PHT sequencer state encoding and the counter update functions.
package bp_pkg;

   localparam int IDX_W_DEFAULT = 10;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_UPD_RD,
      ST_UPD_WR
   } state_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/bp_pht_ctrl_if.sv
// Signal bundle between the PHT controller, the fetch/execute stages and the RAM.
// The slave modport is the controller's view; master is the surrounding pipeline/RAM.
interface bp_pht_ctrl_if #(
   parameter int IDX_W = bp_pkg::IDX_W_DEFAULT
);
   logic             lk_valid;
   logic [IDX_W-1:0] lk_addr;
   logic             lk_ready;
   logic             pred_valid;
   logic             pred_taken;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_addr;
   logic             upd_taken;
   logic             upd_ready;
   logic             init_done;
   logic             ram_en;
   logic             ram_we;
   logic [IDX_W-1:0] ram_addr;
   logic [1:0]       ram_wdata;
   logic [1:0]       ram_rdata;

   modport slave (
      input  lk_valid, lk_addr, upd_valid, upd_addr, upd_taken, ram_rdata,
      output lk_ready, pred_valid, pred_taken, upd_ready, init_done,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output lk_valid, lk_addr, upd_valid, upd_addr, upd_taken, ram_rdata,
      input  lk_ready, pred_valid, pred_taken, upd_ready, init_done,
             ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO buffering resolved-branch updates {addr, taken}.
// Head entry is presented combinationally so the arbiter can issue it in the pop cycle.
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int W     = IDX_W_DEFAULT + 1,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_reg [DEPTH];
   logic [AW:0]  wr_ptr_reg;
   logic [AW:0]  rd_ptr_reg;
   logic         push_en;
   logic         pop_en;

   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_en)
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop_en)
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en)
         mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/bp_pht_ctrl.sv
// PHT sequencer: initialises the counter table, then arbitrates the single RAM port
// between fetch lookups and buffered read-modify-write counter updates.
module bp_pht_ctrl
   import bp_pkg::*;
#(
   parameter int   IDX_W      = IDX_W_DEFAULT,
   parameter ctr_t INIT_CTR   = CTR_ST,
   parameter int   FIFO_DEPTH = 4,
   parameter int   MAX_DEFER  = 8
) (
   input  logic        clk,
   input  logic        rst,
   bp_pht_ctrl_if.slave bus
);

   localparam int DW = $clog2(MAX_DEFER + 1);
   localparam int FW = IDX_W + 1;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic             init_done_reg, init_done_next;
   logic [DW-1:0]    defer_reg, defer_next;
   logic             pred_valid_reg, pred_valid_next;
   logic [IDX_W-1:0] upd_addr_reg, upd_addr_next;
   logic             upd_taken_reg, upd_taken_next;
   ctr_t             rdata_reg, rdata_next;

   logic             fifo_push;
   logic             fifo_pop;
   logic [FW-1:0]    fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             force_upd;
   logic             lk_ready;
   logic             ram_en;
   logic             ram_we;
   logic [IDX_W-1:0] ram_addr;
   ctr_t             ram_wdata;
   logic             upd_ready;

   assign upd_ready = init_done_reg & ~fifo_full;
   assign fifo_push = bus.upd_valid & upd_ready;
   assign force_upd = fifo_full | (defer_reg == DW'(MAX_DEFER));

   bp_upd_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({bus.upd_addr, bus.upd_taken}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_INIT;
         ptr_reg        <= '0;
         init_done_reg  <= 1'b0;
         defer_reg      <= '0;
         pred_valid_reg <= 1'b0;
         upd_addr_reg   <= '0;
         upd_taken_reg  <= 1'b0;
         rdata_reg      <= CTR_SNT;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         init_done_reg  <= init_done_next;
         defer_reg      <= defer_next;
         pred_valid_reg <= pred_valid_next;
         upd_addr_reg   <= upd_addr_next;
         upd_taken_reg  <= upd_taken_next;
         rdata_reg      <= rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      init_done_next  = init_done_reg;
      defer_next      = defer_reg;
      pred_valid_next = 1'b0;
      upd_addr_next   = upd_addr_reg;
      upd_taken_next  = upd_taken_reg;
      rdata_next      = rdata_reg;
      fifo_pop        = 1'b0;
      lk_ready        = 1'b0;
      ram_en          = 1'b0;
      ram_we          = 1'b0;
      ram_addr        = '0;
      ram_wdata       = CTR_SNT;

      // The reset state is INIT, whose decode would otherwise drive a RAM write
      // while rst is held; keep the RAM port quiet until reset is released.
      if (!rst) begin
         unique case (state_reg)
            ST_INIT: begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = ptr_reg;
               ram_wdata = INIT_CTR;
               ptr_next  = ptr_reg + IDX_W'(1);
               if (ptr_reg == '1) begin
                  state_next     = ST_IDLE;
                  init_done_next = 1'b1;
               end
            end
            ST_IDLE: begin
               if (!fifo_empty && (force_upd || !bus.lk_valid)) begin
                  fifo_pop       = 1'b1;
                  ram_en         = 1'b1;
                  ram_addr       = fifo_head[FW-1:1];
                  upd_addr_next  = fifo_head[FW-1:1];
                  upd_taken_next = fifo_head[0];
                  state_next     = ST_UPD_RD;
               end else begin
                  lk_ready = 1'b1;
                  if (bus.lk_valid) begin
                     ram_en          = 1'b1;
                     ram_addr        = bus.lk_addr;
                     pred_valid_next = 1'b1;
                  end
               end
            end
            ST_UPD_RD: begin
               rdata_next = bus.ram_rdata;
               state_next = ST_UPD_WR;
            end
            ST_UPD_WR: begin
               ram_en     = 1'b1;
               ram_we     = 1'b1;
               ram_addr   = upd_addr_reg;
               ram_wdata  = upd_taken_reg ? sat_inc(rdata_reg) : sat_dec(rdata_reg);
               state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
         endcase
      end

      // Starvation guard: count lookups that won while an update was waiting.
      if (fifo_empty || fifo_pop)
         defer_next = '0;
      else if (state_reg == ST_IDLE && lk_ready && bus.lk_valid && defer_reg != DW'(MAX_DEFER))
         defer_next = defer_reg + DW'(1);
   end

   assign bus.lk_ready   = lk_ready;
   assign bus.upd_ready  = upd_ready;
   assign bus.init_done  = init_done_reg;
   assign bus.pred_valid = pred_valid_reg;
   assign bus.pred_taken = pred_valid_reg & bus.ram_rdata[1];
   assign bus.ram_en     = ram_en;
   assign bus.ram_we     = ram_we;
   assign bus.ram_addr   = ram_addr;
   assign bus.ram_wdata  = ram_wdata;

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Bench for bp_pht_ctrl with a 16-entry table: a behavioural RAM, a counter-table
// reference model fed by accepted updates in order, and directed plus random steps.
module tb_bp_pht_ctrl;

   localparam int IDX_W = 4;
   localparam int DEPTH = 16;
   localparam int MAXD  = 8;

   typedef struct {
      int addr;
      bit taken;
   } upd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bp_pht_ctrl_if #(.IDX_W(IDX_W)) bus();

   bp_pht_ctrl #(
      .IDX_W      (IDX_W),
      .INIT_CTR   (2'b11),
      .FIFO_DEPTH (4),
      .MAX_DEFER  (MAXD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural synchronous single-port RAM
   logic [1:0] ram [DEPTH];
   logic [1:0] ram_rdata_q = 2'b00;
   assign bus.ram_rdata = ram_rdata_q;
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            ram_rdata_q <= ram[bus.ram_addr];
      end
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: table contents as implied by init plus in-order updates
   int   mdl [DEPTH];
   upd_t exp_q [$];
   int   init_cnt  = 0;
   bit   done_seen = 0;
   bit   pend      = 0;
   bit   pend_exp  = 0;
   int   streak    = 0;
   int   wr_count  = 0;
   int   last_wr   = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) mdl[i] = 3;
         init_cnt  = 0;
         done_seen = 0;
         pend      = 0;
         streak    = 0;
      end else begin
         if (pend) begin
            chk("pred_valid", bus.pred_valid, 1);
            chk("pred_taken", bus.pred_taken, pend_exp);
         end else begin
            chk("pred_idle", bus.pred_valid, 0);
         end
         pend = 0;
         if (!bus.init_done) begin
            chk("init_lk_ready", bus.lk_ready, 0);
            chk("init_upd_ready", bus.upd_ready, 0);
            if (bus.ram_en) begin
               chk("init_we", bus.ram_we, 1);
               chk("init_addr", bus.ram_addr, init_cnt);
               chk("init_wdata", bus.ram_wdata, 3);
               init_cnt++;
            end
         end else begin
            if (!done_seen) chk("init_len", init_cnt, DEPTH);
            done_seen = 1;
            if (bus.lk_valid && bus.lk_ready) begin
               pend     = 1;
               pend_exp = (mdl[bus.lk_addr] >= 2);
               if (exp_q.size() > 0) begin
                  streak++;
                  chk("defer_bound", streak <= MAXD, 1);
               end else begin
                  streak = 0;
               end
            end else if (!bus.lk_ready || exp_q.size() == 0) begin
               streak = 0;
            end
            if (bus.ram_en && bus.ram_we) begin
               if (exp_q.size() == 0) begin
                  chk("wr_unexpected", 1, 0);
               end else begin
                  upd_t u;
                  int   e;
                  u = exp_q.pop_front();
                  if (u.taken) e = (mdl[u.addr] >= 3) ? 3 : mdl[u.addr] + 1;
                  else         e = (mdl[u.addr] == 0) ? 0 : mdl[u.addr] - 1;
                  chk("wr_addr", bus.ram_addr, u.addr);
                  chk("wr_data", bus.ram_wdata, e);
                  mdl[u.addr] = e;
                  last_wr = int'(bus.ram_wdata);
                  wr_count++;
               end
            end
            if (bus.upd_valid && bus.upd_ready)
               exp_q.push_back('{int'(bus.upd_addr), bus.upd_taken});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init();
      int n = 0;
      while (!bus.init_done && n < 40) begin tick(); n++; end
      if (!bus.init_done) chk("init_timeout", 0, 1);
   endtask

   task automatic wait_wr(input int prev);
      int n = 0;
      while (wr_count == prev && n < 30) begin tick(); n++; end
      if (wr_count == prev) chk("wr_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
      if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
      repeat (3) tick();
   endtask

   task automatic push_one(input int addr, input bit taken);
      bus.upd_valid = 1'b1;
      bus.upd_addr  = IDX_W'(addr);
      bus.upd_taken = taken;
      tick();
      bus.upd_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pred_valid"}, bus.pred_valid, 0);
      chk({tag, "_pred_taken"}, bus.pred_taken, 0);
      chk({tag, "_init_done"},  bus.init_done, 0);
      chk({tag, "_lk_ready"},   bus.lk_ready, 0);
      chk({tag, "_upd_ready"},  bus.upd_ready, 0);
      chk({tag, "_ram_en"},     bus.ram_en, 0);
      chk({tag, "_ram_we"},     bus.ram_we, 0);
      chk({tag, "_ram_addr"},   bus.ram_addr, 0);
      chk({tag, "_ram_wdata"},  bus.ram_wdata, 0);
   endtask

   initial begin
      int sat_exp [8];
      int prev;
      int cnt;
      int n;
      sat_exp = '{2, 1, 0, 0, 1, 2, 3, 3};

      bus.lk_valid  = 1'b0;
      bus.lk_addr   = '0;
      bus.upd_valid = 1'b0;
      bus.upd_addr  = '0;
      bus.upd_taken = 1'b0;

      // Reset state, then the init walk (checked by the monitor)
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      tick();
      rst = 1'b0;
      wait_init();
      chk("init_count", init_cnt, DEPTH);
      tick();

      // Saturating counter behaviour on index 5
      for (int i = 0; i < 8; i++) begin
         prev = wr_count;
         push_one(5, i >= 4);
         wait_wr(prev);
         $display("sat step %0d taken=%0d wdata=%0d", i, i >= 4, last_wr);
         chk("sat_wdata", last_wr, sat_exp[i]);
      end

      // Lookup latency: counter 2 predicts taken, counter 1 predicts not-taken
      for (int i = 0; i < 2; i++) begin
         prev = wr_count;
         push_one(7, 1'b0);
         wait_wr(prev);
         tick();
         bus.lk_valid = 1'b1;
         bus.lk_addr  = IDX_W'(7);
         @(negedge clk);
         chk("lk_ready", bus.lk_ready, 1);
         chk("lk_ram_en", bus.ram_en, 1);
         chk("lk_ram_we", bus.ram_we, 0);
         chk("lk_ram_addr", bus.ram_addr, 7);
         tick();
         bus.lk_valid = 1'b0;
         @(negedge clk);
         $display("lookup idx7 pass %0d pred_valid=%0d pred_taken=%0d", i, bus.pred_valid, bus.pred_taken);
         chk("lat_pred_valid", bus.pred_valid, 1);
         chk("lat_pred_taken", bus.pred_taken, (i == 0) ? 1 : 0);
         tick();
      end

      // Full FIFO forces an update even with lookups pending
      bus.lk_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.lk_addr   = IDX_W'($urandom_range(0, DEPTH-1));
         bus.upd_valid = 1'b1;
         bus.upd_addr  = IDX_W'($urandom_range(0, DEPTH-1));
         bus.upd_taken = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("fill_upd_ready", bus.upd_ready, 1);
         tick();
      end
      bus.upd_valid = 1'b0;
      @(negedge clk);
      $display("fifo full: upd_ready=%0d lk_ready=%0d ram_en=%0d ram_we=%0d", bus.upd_ready, bus.lk_ready, bus.ram_en, bus.ram_we);
      chk("full_upd_ready", bus.upd_ready, 0);
      chk("full_lk_ready", bus.lk_ready, 0);
      chk("full_ram_en", bus.ram_en, 1);
      chk("full_ram_we", bus.ram_we, 0);
      tick();
      bus.lk_valid = 1'b0;
      drain();

      // Defer limit, twice to confirm the counter restarts from zero
      for (int r = 0; r < 2; r++) begin
         bus.lk_valid = 1'b1;
         bus.lk_addr  = IDX_W'($urandom_range(0, DEPTH-1));
         push_one($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)));
         cnt = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.lk_ready) break;
            cnt++;
            tick();
            bus.lk_addr = IDX_W'($urandom_range(0, DEPTH-1));
         end
         $display("defer run %0d: lookups before forced update=%0d", r, cnt);
         chk("defer_count", cnt, MAXD);
         chk("defer_ram_en", bus.ram_en, 1);
         chk("defer_ram_we", bus.ram_we, 0);
         tick();
         bus.lk_valid = 1'b0;
         drain();
      end

      // Random traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         bus.lk_valid  = 1'($urandom_range(0, 1));
         bus.lk_addr   = IDX_W'($urandom_range(0, DEPTH-1));
         bus.upd_valid = ($urandom_range(0, 2) == 0);
         bus.upd_addr  = IDX_W'($urandom_range(0, DEPTH-1));
         bus.upd_taken = 1'($urandom_range(0, 1));
         tick();
      end
      bus.lk_valid  = 1'b0;
      bus.upd_valid = 1'b0;
      drain();
      $display("random phase done: writes=%0d", wr_count);

      // Reset during the write phase of an update to index 3 with more queued
      push_one(3, 1'b0);
      push_one(3, 1'b1);
      push_one(3, 1'b0);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (bus.ram_en && bus.ram_we && bus.ram_addr == IDX_W'(3)) break;
         n++;
      end
      chk("midop_found_wr", n < 20, 1);
      rst = 1'b1;
      #1;
      $display("mid-op reset asserted during write to idx3");
      check_reset_outputs("midop");
      repeat (2) tick();
      rst = 1'b0;
      wait_init();
      prev = wr_count;
      repeat (10) tick();
      @(negedge clk);
      chk("flush_no_writes", wr_count, prev);
      chk("flush_upd_ready", bus.upd_ready, 1);
      chk("flush_lk_ready", bus.lk_ready, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
